bp_be_fe_adapter: RTL and testbench

- Back-end endpoint of the FE↔BE interface.
- Accepts fe_queue packets from the front end, buffers them in order, and presents them to BE issue.
- Turns BE control events into fe_cmd packets: state reset, PC redirect, icache fence and attaboy.
- Discards wrong-path fe_queue packets from the moment a redirect-class command is generated until the FE accepts it.

---
 rtl/bp_be_fe_adapter.sv | 216 +++++++++++++++++++++
 tb/tb_bp_be_fe_adapter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fe_adapter.sv
// Back-end endpoint of the FE<->BE interface: buffers fe_queue packets for issue
// and turns BE control events into fe_cmd packets, flushing wrong-path packets.
module bp_be_fe_adapter #(
    parameter int unsigned vaddr_width_p               = 39,
    parameter int unsigned fe_queue_width_p            = 128,
    parameter int unsigned branch_metadata_fwd_width_p = 36,
    parameter int unsigned fe_queue_els_p              = 8,
    parameter int unsigned cmd_fifo_els_p              = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [vaddr_width_p-1:0]               cfg_boot_pc_i,

    input  logic [fe_queue_width_p-1:0]            fe_queue_i,
    input  logic                                   fe_queue_v_i,
    output logic                                   fe_queue_ready_o,

    output logic [fe_queue_width_p-1:0]            issue_pkt_o,
    output logic                                   issue_v_o,
    input  logic                                   issue_yumi_i,

    input  logic                                   be_cmd_v_i,
    output logic                                   be_cmd_ready_o,
    input  logic [1:0]                             be_cmd_op_i,
    input  logic [vaddr_width_p-1:0]               be_cmd_pc_i,
    input  logic                                   be_cmd_taken_i,
    input  logic [branch_metadata_fwd_width_p-1:0] be_cmd_metadata_i,
    input  logic [1:0]                             be_cmd_priv_i,
    input  logic                                   be_cmd_tr_en_i,

    output logic                                   fe_cmd_v_o,
    input  logic                                   fe_cmd_yumi_i,
    output logic [2:0]                             fe_cmd_opcode_o,
    output logic                                   fe_cmd_subopcode_o,
    output logic [vaddr_width_p-1:0]               fe_cmd_vaddr_o,
    output logic                                   fe_cmd_taken_o,
    output logic [branch_metadata_fwd_width_p-1:0] fe_cmd_metadata_o,
    output logic [1:0]                             fe_cmd_priv_o,
    output logic                                   fe_cmd_tr_en_o,

    output logic                                   busy_o
);

    localparam int unsigned FqIdxW  = $clog2(fe_queue_els_p);
    localparam int unsigned FqPtrW  = FqIdxW + 1;
    localparam int unsigned CmdIdxW = $clog2(cmd_fifo_els_p);
    localparam int unsigned CmdPtrW = CmdIdxW + 1;
    localparam int unsigned OutW    = $clog2(cmd_fifo_els_p + 2);

    localparam logic [2:0] OpStateReset  = 3'd0;
    localparam logic [2:0] OpPcRedirect  = 3'd1;
    localparam logic [2:0] OpIcacheFence = 3'd2;
    localparam logic [2:0] OpAttaboy     = 3'd3;
    localparam logic       SubopBranchMispredict = 1'b0;
    localparam logic       SubopTrap             = 1'b1;

    typedef enum logic [1:0] {
        e_boot  = 2'd0,
        e_flush = 2'd1,
        e_run   = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]                             opcode;
        logic                                   subopcode;
        logic [vaddr_width_p-1:0]               vaddr;
        logic                                   taken;
        logic [branch_metadata_fwd_width_p-1:0] metadata;
        logic [1:0]                             priv;
        logic                                   tr_en;
    } fe_cmd_t;

    state_e               state_q, state_d;
    logic [FqPtrW-1:0]    fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
    logic [CmdPtrW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [OutW-1:0]      outstanding_q, outstanding_d;
    logic                 busy_q, busy_d;

    logic [fe_queue_width_p-1:0] fq_mem [fe_queue_els_p];
    fe_cmd_t                     cmd_mem [cmd_fifo_els_p];

    logic    fq_empty, fq_full, cmd_empty, cmd_full;
    logic    fq_push, fq_pop, cmd_enq, cmd_deq, redirect, redirect_deq;
    fe_cmd_t cmd_new, cmd_head, cmd_out;

    // Occupancy comes only from registered pointers, so ready/valid have no input path
    assign fq_empty  = (fq_wr_q == fq_rd_q);
    assign fq_full   = (fq_wr_q[FqIdxW] != fq_rd_q[FqIdxW])
                     && (fq_wr_q[FqIdxW-1:0] == fq_rd_q[FqIdxW-1:0]);
    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CmdIdxW] != cmd_rd_q[CmdIdxW])
                     && (cmd_wr_q[CmdIdxW-1:0] == cmd_rd_q[CmdIdxW-1:0]);

    assign fe_queue_ready_o = (state_q == e_flush) | ((state_q == e_run) & ~fq_full);
    assign be_cmd_ready_o   = (state_q != e_boot) & ~cmd_full;
    assign issue_v_o        = ~fq_empty;
    assign fe_cmd_v_o       = ~cmd_empty;
    assign busy_o           = busy_q;

    assign cmd_head = cmd_mem[cmd_rd_q[CmdIdxW-1:0]];

    // Data outputs are zeroed while their buffer is empty so storage needs no reset
    assign issue_pkt_o = fq_empty ? '0 : fq_mem[fq_rd_q[FqIdxW-1:0]];
    assign cmd_out     = cmd_empty ? '0 : cmd_head;

    assign fe_cmd_opcode_o    = cmd_out.opcode;
    assign fe_cmd_subopcode_o = cmd_out.subopcode;
    assign fe_cmd_vaddr_o     = cmd_out.vaddr;
    assign fe_cmd_taken_o     = cmd_out.taken;
    assign fe_cmd_metadata_o  = cmd_out.metadata;
    assign fe_cmd_priv_o      = cmd_out.priv;
    assign fe_cmd_tr_en_o     = cmd_out.tr_en;

    // Next-state: command generation, flush bookkeeping and buffer pointers
    always_comb begin
        state_d       = state_q;
        cmd_new       = '0;
        cmd_enq       = 1'b0;
        redirect      = 1'b0;
        fq_wr_d       = fq_wr_q;
        fq_rd_d       = fq_rd_q;
        cmd_wr_d      = cmd_wr_q;
        cmd_rd_d      = cmd_rd_q;
        outstanding_d = outstanding_q;
        busy_d        = busy_q;

        if (state_q == e_boot) begin
            cmd_enq         = 1'b1;
            redirect        = 1'b1;
            cmd_new.opcode  = OpStateReset;
            cmd_new.vaddr   = cfg_boot_pc_i;
            cmd_new.priv    = 2'b11;
        end else if (be_cmd_v_i && be_cmd_ready_o) begin
            cmd_enq          = 1'b1;
            cmd_new.vaddr    = be_cmd_pc_i;
            cmd_new.taken    = be_cmd_taken_i;
            cmd_new.metadata = be_cmd_metadata_i;
            unique case (be_cmd_op_i)
                2'd0: cmd_new.opcode = OpAttaboy;
                2'd1: begin
                    cmd_new.opcode    = OpPcRedirect;
                    cmd_new.subopcode = SubopBranchMispredict;
                    redirect          = 1'b1;
                end
                2'd2: begin
                    cmd_new.opcode    = OpPcRedirect;
                    cmd_new.subopcode = SubopTrap;
                    cmd_new.priv      = be_cmd_priv_i;
                    cmd_new.tr_en     = be_cmd_tr_en_i;
                    redirect          = 1'b1;
                end
                default: begin
                    cmd_new.opcode = OpIcacheFence;
                    redirect       = 1'b1;
                end
            endcase
        end

        cmd_deq      = fe_cmd_yumi_i & ~cmd_empty;
        redirect_deq = cmd_deq & (cmd_head.opcode != OpAttaboy);
        cmd_wr_d     = cmd_wr_q + CmdPtrW'(cmd_enq);
        cmd_rd_d     = cmd_rd_q + CmdPtrW'(cmd_deq);
        outstanding_d = outstanding_q + OutW'(redirect) - OutW'(redirect_deq);

        // Packets are kept only in e_run; a redirect empties the buffer outright
        fq_pop  = issue_yumi_i & ~fq_empty;
        fq_push = fe_queue_v_i & fe_queue_ready_o & (state_q == e_run) & ~redirect;
        if (redirect) begin
            fq_wr_d = '0;
            fq_rd_d = '0;
        end else begin
            fq_wr_d = fq_wr_q + FqPtrW'(fq_push);
            fq_rd_d = fq_rd_q + FqPtrW'(fq_pop);
        end

        if (redirect) begin
            state_d = e_flush;
        end else if ((state_q == e_flush) && (outstanding_d == '0)) begin
            state_d = e_run;
        end

        busy_d = (state_d != e_run) | (fq_wr_d != fq_rd_d) | (cmd_wr_d != cmd_rd_d);
    end

    // Control state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= e_boot;
            fq_wr_q       <= '0;
            fq_rd_q       <= '0;
            cmd_wr_q      <= '0;
            cmd_rd_q      <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fq_wr_q       <= fq_wr_d;
            fq_rd_q       <= fq_rd_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_rd_q      <= cmd_rd_d;
            outstanding_q <= outstanding_d;
            busy_q        <= busy_d;
        end
    end

    // Buffer storage
    always_ff @(posedge clk_i) begin
        if (fq_push) begin
            fq_mem[fq_wr_q[FqIdxW-1:0]] <= fe_queue_i;
        end
        if (cmd_enq) begin
            cmd_mem[cmd_wr_q[CmdIdxW-1:0]] <= cmd_new;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_adapter.sv
// Bench for bp_be_fe_adapter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_bp_be_fe_adapter;

    logic         clk;
    logic         rst_n;
    logic [38:0]  boot_pc;
    logic [127:0] fq_pkt;
    logic         fq_v;
    logic         fe_queue_ready_o;
    logic [127:0] issue_pkt_o;
    logic         issue_v_o;
    logic         issue_yumi;
    logic         be_v;
    logic         be_cmd_ready_o;
    logic [1:0]   be_op;
    logic [38:0]  be_pc;
    logic         be_taken;
    logic [35:0]  be_md;
    logic [1:0]   be_priv;
    logic         be_tr;
    logic         fe_cmd_v_o;
    logic         cmd_yumi;
    logic [2:0]   fe_cmd_opcode_o;
    logic         fe_cmd_subopcode_o;
    logic [38:0]  fe_cmd_vaddr_o;
    logic         fe_cmd_taken_o;
    logic [35:0]  fe_cmd_metadata_o;
    logic [1:0]   fe_cmd_priv_o;
    logic         fe_cmd_tr_en_o;
    logic         busy_o;

    bp_be_fe_adapter dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .cfg_boot_pc_i      (boot_pc),
        .fe_queue_i         (fq_pkt),
        .fe_queue_v_i       (fq_v),
        .fe_queue_ready_o   (fe_queue_ready_o),
        .issue_pkt_o        (issue_pkt_o),
        .issue_v_o          (issue_v_o),
        .issue_yumi_i       (issue_yumi),
        .be_cmd_v_i         (be_v),
        .be_cmd_ready_o     (be_cmd_ready_o),
        .be_cmd_op_i        (be_op),
        .be_cmd_pc_i        (be_pc),
        .be_cmd_taken_i     (be_taken),
        .be_cmd_metadata_i  (be_md),
        .be_cmd_priv_i      (be_priv),
        .be_cmd_tr_en_i     (be_tr),
        .fe_cmd_v_o         (fe_cmd_v_o),
        .fe_cmd_yumi_i      (cmd_yumi),
        .fe_cmd_opcode_o    (fe_cmd_opcode_o),
        .fe_cmd_subopcode_o (fe_cmd_subopcode_o),
        .fe_cmd_vaddr_o     (fe_cmd_vaddr_o),
        .fe_cmd_taken_o     (fe_cmd_taken_o),
        .fe_cmd_metadata_o  (fe_cmd_metadata_o),
        .fe_cmd_priv_o      (fe_cmd_priv_o),
        .fe_cmd_tr_en_o     (fe_cmd_tr_en_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        sub;
        logic [38:0] vaddr;
        logic        taken;
        logic [35:0] md;
        logic [1:0]  priv;
        logic        tr_en;
    } cmd_t;

    typedef enum int {M_BOOT, M_FLUSH, M_RUN} mode_t;

    // Reference model: what the FE/BE should see, in terms of queues and a mode
    logic [127:0] fq[$];
    cmd_t         cq[$];
    mode_t        mode;
    int           outst;
    bit           busy_exp;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t map_cmd(input logic [1:0] op, input logic [38:0] pc,
                                      input logic tk, input logic [35:0] md,
                                      input logic [1:0] pv, input logic tr);
        cmd_t c;
        c.vaddr = pc; c.taken = tk; c.md = md;
        c.sub = 1'b0; c.priv = 2'b00; c.tr_en = 1'b0;
        case (op)
            2'd0: c.op = 3'd3;
            2'd1: c.op = 3'd1;
            2'd2: begin c.op = 3'd1; c.sub = 1'b1; c.priv = pv; c.tr_en = tr; end
            default: c.op = 3'd2;
        endcase
        return c;
    endfunction

    function automatic bit exp_fq_ready();
        return (mode == M_RUN) ? (fq.size() < 8) : (mode == M_FLUSH);
    endfunction

    function automatic bit exp_be_ready();
        return (mode != M_BOOT) && (cq.size() < 4);
    endfunction

    task automatic model_reset();
        fq.delete();
        cq.delete();
        mode     = M_BOOT;
        outst    = 0;
        busy_exp = 1'b0;
    endtask

    task automatic model_step();
        cmd_t c;
        bit   enq   = 1'b0;
        bit   redir = 1'b0;
        bit   dec;
        c = map_cmd(2'd0, 39'd0, 1'b0, 36'd0, 2'd0, 1'b0);
        if (mode == M_BOOT) begin
            c.op = 3'd0; c.vaddr = boot_pc; c.priv = 2'b11; c.taken = 1'b0; c.md = '0;
            enq = 1'b1; redir = 1'b1;
        end else if (be_v) begin
            c = map_cmd(be_op, be_pc, be_taken, be_md, be_priv, be_tr);
            enq = 1'b1; redir = (be_op != 2'd0);
        end
        dec = cmd_yumi && (cq.size() > 0) && (cq[0].op != 3'd3);
        if (cmd_yumi && cq.size() > 0) void'(cq.pop_front());
        if (enq) cq.push_back(c);
        outst = outst + int'(redir) - int'(dec);
        if (redir) begin
            fq.delete();
        end else begin
            if (issue_yumi && fq.size() > 0) void'(fq.pop_front());
            if (fq_v && mode == M_RUN) fq.push_back(fq_pkt);
        end
        if (redir) mode = M_FLUSH;
        else if (mode == M_FLUSH && outst == 0) mode = M_RUN;
        busy_exp = (mode != M_RUN) || (fq.size() > 0) || (cq.size() > 0);
    endtask

    task automatic check_all();
        cmd_t h;
        h = map_cmd(2'd0, 39'd0, 1'b0, 36'd0, 2'd0, 1'b0);
        h.op = 3'd0;
        if (cq.size() > 0) h = cq[0];
        chk("issue_v",     128'(issue_v_o),          128'(fq.size() > 0));
        chk("issue_pkt",   issue_pkt_o,              (fq.size() > 0) ? fq[0] : 128'(0));
        chk("fq_ready",    128'(fe_queue_ready_o),   128'(exp_fq_ready()));
        chk("be_ready",    128'(be_cmd_ready_o),     128'(exp_be_ready()));
        chk("cmd_v",       128'(fe_cmd_v_o),         128'(cq.size() > 0));
        chk("cmd_opcode",  128'(fe_cmd_opcode_o),    128'(h.op));
        chk("cmd_subop",   128'(fe_cmd_subopcode_o), 128'(h.sub));
        chk("cmd_vaddr",   128'(fe_cmd_vaddr_o),     128'(h.vaddr));
        chk("cmd_taken",   128'(fe_cmd_taken_o),     128'(h.taken));
        chk("cmd_md",      128'(fe_cmd_metadata_o),  128'(h.md));
        chk("cmd_priv",    128'(fe_cmd_priv_o),      128'(h.priv));
        chk("cmd_tr_en",   128'(fe_cmd_tr_en_o),     128'(h.tr_en));
        chk("busy",        128'(busy_o),             128'(busy_exp));
    endtask

    task automatic idle();
        fq_v = 1'b0; fq_pkt = '0; issue_yumi = 1'b0;
        be_v = 1'b0; be_op = '0; be_pc = '0; be_taken = 1'b0; be_md = '0;
        be_priv = '0; be_tr = 1'b0; cmd_yumi = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Reset is asserted between edges and outputs are checked before any edge
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_issue_v",  128'(issue_v_o),        128'(0));
        chk("rst_issue_pk", issue_pkt_o,            128'(0));
        chk("rst_fq_ready", 128'(fe_queue_ready_o), 128'(0));
        chk("rst_be_ready", 128'(be_cmd_ready_o),   128'(0));
        chk("rst_cmd_v",    128'(fe_cmd_v_o),       128'(0));
        chk("rst_cmd_va",   128'(fe_cmd_vaddr_o),   128'(0));
        chk("rst_busy",     128'(busy_o),           128'(0));
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("boot_fq_ready", 128'(fe_queue_ready_o), 128'(0));
    endtask

    task automatic push_pkt(input logic [127:0] p);
        fq_v = 1'b1; fq_pkt = p;
    endtask

    task automatic be_cmd(input logic [1:0] op, input logic [38:0] pc, input logic tk,
                          input logic [35:0] md, input logic [1:0] pv, input logic tr);
        be_v = 1'b1; be_op = op; be_pc = pc; be_taken = tk; be_md = md; be_priv = pv; be_tr = tr;
    endtask

    initial begin
        rst_n   = 1'b1;
        boot_pc = 39'h80000000;
        idle();
        model_reset();
        do_reset();

        // Boot command, then the packet accepted on the yumi cycle is dropped
        step();
        chk("lit_boot_v",    128'(fe_cmd_v_o),      128'(1));
        chk("lit_boot_op",   128'(fe_cmd_opcode_o), 128'(0));
        chk("lit_boot_pc",   128'(fe_cmd_vaddr_o),  128'(39'h80000000));
        chk("lit_boot_priv", 128'(fe_cmd_priv_o),   128'(3));
        push_pkt(128'hA); cmd_yumi = 1'b1;
        step();
        chk("lit_drop_yumi", 128'(issue_v_o), 128'(0));
        idle(); push_pkt(128'hB);
        step();
        chk("lit_first_pkt", issue_pkt_o, 128'hB);
        idle(); issue_yumi = 1'b1;
        step();

        // Fill the issue buffer, then drain in order
        for (int i = 0; i < 8; i++) begin
            idle(); push_pkt(128'h100 + 128'(i));
            step();
        end
        chk("lit_full_ready", 128'(fe_queue_ready_o), 128'(0));
        chk("lit_full_head",  issue_pkt_o,            128'h100);
        idle(); issue_yumi = 1'b1;
        step();
        chk("lit_ready_back", 128'(fe_queue_ready_o), 128'(1));
        for (int i = 1; i < 8; i++) begin
            chk("lit_drain", issue_pkt_o, 128'h100 + 128'(i));
            step();
        end
        idle();

        // Mispredict clears buffered packets; stalled yumi keeps dropping
        for (int i = 0; i < 3; i++) begin
            push_pkt(128'h200 + 128'(i));
            step();
        end
        idle(); be_cmd(2'd1, 39'h1000, 1'b1, 36'h5, 2'd0, 1'b0);
        step();
        chk("lit_mp_issue_v", 128'(issue_v_o),          128'(0));
        chk("lit_mp_op",      128'(fe_cmd_opcode_o),    128'(1));
        chk("lit_mp_subop",   128'(fe_cmd_subopcode_o), 128'(0));
        chk("lit_mp_pc",      128'(fe_cmd_vaddr_o),     128'(39'h1000));
        for (int i = 0; i < 3; i++) begin
            idle(); push_pkt(128'h300 + 128'(i));
            step();
            chk("lit_mp_drop", 128'(issue_v_o), 128'(0));
        end
        idle(); push_pkt(128'h3FF); cmd_yumi = 1'b1;
        step();
        idle(); push_pkt(128'h400);
        step();
        chk("lit_mp_after", issue_pkt_o, 128'h400);
        idle(); issue_yumi = 1'b1;
        step();

        // Attaboys fill the command buffer without flushing
        for (int i = 0; i < 4; i++) begin
            idle(); be_cmd(2'd0, 39'h2000 + 39'(i), 1'(i), 36'h10 + 36'(i), 2'd0, 1'b0);
            step();
        end
        chk("lit_ab_be_ready", 128'(be_cmd_ready_o),   128'(0));
        chk("lit_ab_fq_ready", 128'(fe_queue_ready_o), 128'(1));
        for (int i = 0; i < 4; i++) begin
            chk("lit_ab_md",    128'(fe_cmd_metadata_o), 128'(36'h10 + 36'(i)));
            chk("lit_ab_taken", 128'(fe_cmd_taken_o),    128'(i % 2));
            idle(); cmd_yumi = 1'b1;
            step();
        end

        // Back-to-back mispredict and trap: two outstanding redirects
        idle(); be_cmd(2'd1, 39'h3000, 1'b0, 36'h7, 2'd0, 1'b0);
        step();
        idle(); be_cmd(2'd2, 39'h4000, 1'b0, 36'h0, 2'd1, 1'b1);
        step();
        idle(); push_pkt(128'h500); cmd_yumi = 1'b1;
        step();
        chk("lit_trap_op",   128'(fe_cmd_opcode_o),    128'(1));
        chk("lit_trap_sub",  128'(fe_cmd_subopcode_o), 128'(1));
        chk("lit_trap_priv", 128'(fe_cmd_priv_o),      128'(1));
        chk("lit_trap_tr",   128'(fe_cmd_tr_en_o),     128'(1));
        idle(); push_pkt(128'h501); cmd_yumi = 1'b1;
        step();
        chk("lit_trap_drop", 128'(issue_v_o), 128'(0));
        idle(); push_pkt(128'h502);
        step();
        chk("lit_trap_after", issue_pkt_o, 128'h502);

        // Reset with both buffers occupied, then a fresh boot
        idle(); be_cmd(2'd0, 39'h5000, 1'b1, 36'h9, 2'd0, 1'b0);
        step();
        idle();
        boot_pc = 39'h40000000;
        do_reset();
        step();
        chk("lit_reboot_op", 128'(fe_cmd_opcode_o), 128'(0));
        chk("lit_reboot_pc", 128'(fe_cmd_vaddr_o),  128'(39'h40000000));
        cmd_yumi = 1'b1;
        step();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            if (exp_fq_ready() && ($urandom % 2 == 0)) push_pkt({$urandom, $urandom, $urandom, $urandom});
            if (fq.size() > 0 && ($urandom % 3 != 0)) issue_yumi = 1'b1;
            if (exp_be_ready() && ($urandom % 4 == 0)) begin
                be_cmd(($urandom % 2 == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
                       39'({$urandom, $urandom}), 1'($urandom), 36'({$urandom, $urandom}),
                       2'($urandom), 1'($urandom));
            end
            if (cq.size() > 0 && ($urandom % 2 == 0)) cmd_yumi = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
